// File: rtl/alu.sv
// MIPS-style integer ALU with registered result and zero flag (1-cycle latency).
// Optional signed-overflow output is enabled by defining ALU_OVERFLOW_EN.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             zeroFlag
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             less_than;
    logic [WIDTH-1:0] next_result;
    logic             next_zero;

    assign sum       = operand1 + operand2;
    assign diff      = operand1 - operand2;
    assign less_than = $signed(operand1) < $signed(operand2);

    // Unassigned codes fall through to zero so branch logic sees zeroFlag=1.
    always_comb begin
        next_result = '0;
        case (operation)
            OP_AND:  next_result = operand1 & operand2;
            OP_OR:   next_result = operand1 | operand2;
            OP_ADD:  next_result = sum;
            OP_SUB:  next_result = diff;
            OP_SLT:  next_result = {{(WIDTH-1){1'b0}}, less_than};
            OP_NOR:  next_result = ~(operand1 | operand2);
            default: next_result = '0;
        endcase
    end

    assign next_zero = (next_result == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result   <= '0;
            zeroFlag <= 1'b1;
        end else begin
            result   <= next_result;
            zeroFlag <= next_zero;
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic sign_a;
    logic sign_b;
    logic next_overflow;

    assign sign_a = operand1[WIDTH-1];
    assign sign_b = operand2[WIDTH-1];

    // Signed overflow: the result sign disagrees with what the operand signs imply.
    always_comb begin
        next_overflow = 1'b0;
        case (operation)
            OP_ADD:  next_overflow = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
            OP_SUB:  next_overflow = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
            default: next_overflow = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= next_overflow;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases followed by randomized ops
// compared against a behavioural model; covers ALU_OVERFLOW_EN when defined.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  operation;
    logic [31:0] result;
    logic        zeroFlag;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] expResult;
    logic        expZero;
    logic        expOvf;

    alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand1  (operand1),
        .operand2  (operand2),
        .operation (operation),
        .result    (result),
        .zeroFlag  (zeroFlag)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain signed/unsigned arithmetic on wide integers.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] op, input logic rstn,
                                     output logic [31:0] r, output logic z,
                                     output logic ov);
        longint sa;
        longint sb;
        longint wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'd0;
        ov = 1'b0;
        if (rstn) begin
            case (op)
                4'd0:  r = a & b;
                4'd1:  r = a | b;
                4'd2: begin
                    wide = sa + sb;
                    r    = wide[31:0];
                    ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
                end
                4'd6: begin
                    wide = sa - sb;
                    r    = wide[31:0];
                    ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
                end
                4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
                4'd12: r = ~(a | b);
                default: r = 32'd0;
            endcase
        end
        z = (r == 32'd0);
    endfunction

    // Drive one op on the falling edge, let the rising edge capture it, settle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic rstn);
        @(negedge clk);
        operand1  = a;
        operand2  = b;
        operation = op;
        rst_n     = rstn;
        refModel(a, b, op, rstn, expResult, expZero, expOvf);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        assertCount++;
        assert (result === expResult) else begin
            failCount++;
            $error("[TB] FAIL %s result: got %h expected %h", tag, result, expResult);
        end
        assertCount++;
        assert (zeroFlag === expZero) else begin
            failCount++;
            $error("[TB] FAIL %s zeroFlag: got %b expected %b", tag, zeroFlag, expZero);
        end
`ifdef ALU_OVERFLOW_EN
        assertCount++;
        assert (overflow === expOvf) else begin
            failCount++;
            $error("[TB] FAIL %s overflow: got %b expected %b", tag, overflow, expOvf);
        end
`endif
    endtask

    logic [3:0] opTable [0:5] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;
        logic        rrst;

        rst_n     = 1'b0;
        operand1  = 32'd0;
        operand2  = 32'd0;
        operation = 4'd0;

        applyStimulus(32'd0, 32'd0, 4'd0, 1'b0);
        checkOutput("reset");

        applyStimulus(32'd5, 32'd6, 4'b0010, 1'b1);
        checkOutput("add_5_6");
        applyStimulus(32'd15, 32'd15, 4'b0110, 1'b1);
        checkOutput("sub_15_15");
        applyStimulus(32'hAAAAAAAA, 32'h55555555, 4'b0001, 1'b1);
        checkOutput("or_alt");
        applyStimulus(32'hAAAAAAAA, 32'h55555555, 4'b1100, 1'b1);
        checkOutput("nor_alt");
        applyStimulus(32'd15, 32'd15, 4'b0000, 1'b1);
        checkOutput("and_15_15");
        applyStimulus(32'd15, 32'd16, 4'b0111, 1'b1);
        checkOutput("slt_15_16");
        applyStimulus(32'h80000000, 32'd1, 4'b0111, 1'b1);
        checkOutput("slt_neg");
        applyStimulus(32'd16, 32'd15, 4'b0111, 1'b1);
        checkOutput("slt_16_15");
        applyStimulus(32'h1234, 32'h1234, 4'b0111, 1'b1);
        checkOutput("slt_equal");
        applyStimulus(32'd5, 32'd6, 4'b1111, 1'b1);
        checkOutput("undef_op");
        applyStimulus(32'hFFFFFFFF, 32'd1, 4'b0010, 1'b1);
        checkOutput("add_wrap");
        applyStimulus(32'd0, 32'd1, 4'b0110, 1'b1);
        checkOutput("sub_wrap");
        applyStimulus(32'd5, 32'd6, 4'b0010, 1'b0);
        checkOutput("reset_during_add");
        applyStimulus(32'h7FFFFFFF, 32'd1, 4'b0010, 1'b1);
        checkOutput("add_ovf");
        applyStimulus(32'h80000000, 32'd1, 4'b0110, 1'b1);
        checkOutput("sub_ovf");
        applyStimulus(32'd5, 32'd6, 4'b0010, 1'b1);
        checkOutput("add_no_ovf");

        // Hold check: outputs must not change between edges.
        @(negedge clk);
        operand1  = 32'hDEADBEEF;
        operation = 4'b0001;
        #2;
        checkOutput("hold");

        for (int i = 0; i < 300; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) ra = {$urandom_range(0, 1) == 1, 31'h0} ^ 32'h7FFFFFFF;
            rop  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                               : opTable[$urandom_range(0, 5)];
            rrst = ($urandom_range(0, 15) != 0);
            applyStimulus(ra, rb, rop, rrst);
            checkOutput("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
